ff_upsizer: RTL and testbench

- Valid/ready width up-converter sitting directly upstream of the forward pipe stage.
- Packs RATIO consecutive narrow beats of WD bits into one output word of RATIO*WD bits, LSB lane first.
- A packet end (s_last) flushes a partial word early, with per-lane keep bits.
- The output is fully registered, so m_valid/m_data/m_keep/m_last come straight from flops and can drive the downstream pipe stage directly.

---
 rtl/ff_pkg.sv | 15 +
 rtl/ff_if.sv | 44 ++++
 rtl/ff_lane_acc.sv | 37 +++
 rtl/ff_upsizer.sv | 97 +++++++++
 tb/tb_ff_upsizer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ff_pkg.sv
// Shared constants and helpers for the width up-converter.
// Reused by the pipe stage and the bench.
package ff_pkg;

  localparam int FF_WD    = 8;
  localparam int FF_RATIO = 4;

  function automatic logic lane_sel(
    input int idx,
    input int lane
  );
    return idx == lane;
  endfunction

endpackage

// File: rtl/ff_if.sv
// Narrow-in / wide-out valid/ready bundle for ff_upsizer.
// master drives beats and m_ready; slave is the converter.
interface ff_if
  import ff_pkg::*;
#(
  parameter int WD    = FF_WD,
  parameter int RATIO = FF_RATIO
) ();

  logic                  s_valid;
  logic [WD-1:0]         s_data;
  logic                  s_last;
  logic                  s_ready;
  logic                  m_valid;
  logic [RATIO*WD-1:0]   m_data;
  logic [RATIO-1:0]      m_keep;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_data,
    input  m_keep,
    input  m_last
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_data,
    output m_keep,
    output m_last
  );

endinterface

// File: rtl/ff_lane_acc.sv
// Lane accumulator: RATIO lanes of WD bits with keep flags.
// clr empties all lanes; wr fills lane idx.
module ff_lane_acc
  import ff_pkg::*;
#(
  parameter  int WD    = FF_WD,
  parameter  int RATIO = FF_RATIO,
  localparam int CW    = $clog2(RATIO)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr,
  input  logic [CW-1:0]       idx,
  input  logic [WD-1:0]       din,
  output logic [RATIO*WD-1:0] acc,
  output logic [RATIO-1:0]    keep
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      keep <= '0;
    end else if (clr) begin
      acc  <= '0;
      keep <= '0;
    end else if (wr) begin
      for (int i = 0; i < RATIO; i++) begin
        if (lane_sel(int'(idx), i)) begin
          acc[i*WD +: WD] <= din;
          keep[i]         <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ff_upsizer.sv
// Packs RATIO narrow beats into one registered wide word.
// s_last flushes a partial word with per-lane keep.
module ff_upsizer
  import ff_pkg::*;
#(
  parameter int WD    = FF_WD,
  parameter int RATIO = FF_RATIO
) (
  input  logic clk,
  input  logic rst_n,
  ff_if.slave  bus
);

  localparam int CW = $clog2(RATIO);

  logic [CW-1:0]       cnt;
  logic                s_fire;
  logic                m_fire;
  logic                at_top;
  logic                emit;
  logic                fill;
  logic [RATIO*WD-1:0] acc;
  logic [RATIO-1:0]    acc_keep;
  logic [RATIO*WD-1:0] word;
  logic [RATIO-1:0]    keep_nxt;
  logic                m_valid_q;
  logic [RATIO*WD-1:0] m_data_q;
  logic [RATIO-1:0]    m_keep_q;
  logic                m_last_q;

  // Ready only looks at the output slot, never at s_valid.
  assign bus.s_ready = ~m_valid_q | bus.m_ready;

  assign s_fire = bus.s_valid & bus.s_ready;
  assign m_fire = m_valid_q & bus.m_ready;
  assign at_top = cnt == CW'(RATIO - 1);
  assign emit   = s_fire & (at_top | bus.s_last);
  assign fill   = s_fire & ~emit;

  ff_lane_acc #(
    .WD    (WD),
    .RATIO (RATIO)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (emit),
    .wr    (fill),
    .idx   (cnt),
    .din   (bus.s_data),
    .acc   (acc),
    .keep  (acc_keep)
  );

  // Completing beat merges into lane cnt on its way out.
  always_comb begin
    word     = acc;
    keep_nxt = acc_keep;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_sel(int'(cnt), i)) begin
        word[i*WD +: WD] = bus.s_data;
        keep_nxt[i]      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (emit) begin
      cnt <= '0;
    end else if (fill) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (emit) begin
      m_valid_q <= 1'b1;
      m_data_q  <= word;
      m_keep_q  <= keep_nxt;
      m_last_q  <= bus.s_last;
    end else if (m_fire) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_keep  = m_keep_q;
  assign bus.m_last  = m_last_q;

endmodule

// File: tb/tb_ff_upsizer.sv
// Directed + random bench for ff_upsizer (WD=8, RATIO=4).
// Monitor samples on the falling edge; stimulus moves at posedge+2.
module tb_ff_upsizer;
  import ff_pkg::*;

  localparam int WD    = FF_WD;
  localparam int RATIO = FF_RATIO;
  localparam int OW    = RATIO * WD;

  typedef struct packed {
    logic [OW-1:0]    d;
    logic [RATIO-1:0] k;
    logic             l;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rand_mr = 1'b0;

  int checks   = 0;
  int failures = 0;

  word_t            sb[$];
  word_t            exp_w;
  word_t            held;
  logic             hold_pend = 1'b0;
  logic [OW-1:0]    mdl_acc   = '0;
  logic [RATIO-1:0] mdl_keep  = '0;
  int               mdl_cnt   = 0;

  always #5 clk = ~clk;

  ff_if #(.WD(WD), .RATIO(RATIO)) bus ();

  ff_upsizer #(
    .WD    (WD),
    .RATIO (RATIO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Scoreboard: beats build expected words; output fires pop them.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
      mdl_acc   = '0;
      mdl_keep  = '0;
      mdl_cnt   = 0;
      sb.delete();
    end else begin
      chk("s_ready_rule", 64'(bus.s_ready),
          64'(!bus.m_valid || bus.m_ready));
      if (hold_pend) begin
        chk("hold_valid", 64'(bus.m_valid), 64'(1));
        chk("hold_data", 64'(bus.m_data), 64'(held.d));
        chk("hold_keep", 64'(bus.m_keep), 64'(held.k));
        chk("hold_last", 64'(bus.m_last), 64'(held.l));
      end
      hold_pend = bus.m_valid && !bus.m_ready;
      held      = {bus.m_data, bus.m_keep, bus.m_last};
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'(1));
        end else begin
          exp_w = sb.pop_front();
          chk("sb_data", 64'(bus.m_data), 64'(exp_w.d));
          chk("sb_keep", 64'(bus.m_keep), 64'(exp_w.k));
          chk("sb_last", 64'(bus.m_last), 64'(exp_w.l));
        end
      end
      if (bus.s_valid && bus.s_ready) begin
        mdl_acc[mdl_cnt*WD +: WD] = bus.s_data;
        mdl_keep[mdl_cnt]         = 1'b1;
        if (mdl_cnt == RATIO - 1 || bus.s_last) begin
          sb.push_back({mdl_acc, mdl_keep, bus.s_last});
          mdl_acc  = '0;
          mdl_keep = '0;
          mdl_cnt  = 0;
        end else begin
          mdl_cnt++;
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_mr) bus.m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic put_beat(
    input logic [WD-1:0] d,
    input logic          l
  );
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (!bus.s_ready && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 500) chk("put_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int cyc);
    bus.s_valid = 1'b0;
    repeat (cyc) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.m_valid) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_sb", 64'(sb.size()), 64'(0));
    chk("drain_valid", 64'(bus.m_valid), 64'(0));
  endtask

  task automatic chk_word(
    input string            tag,
    input logic [OW-1:0]    d,
    input logic [RATIO-1:0] k,
    input logic             l
  );
    chk({tag, "_valid"}, 64'(bus.m_valid), 64'(1));
    chk({tag, "_data"}, 64'(bus.m_data), 64'(d));
    chk({tag, "_keep"}, 64'(bus.m_keep), 64'(k));
    chk({tag, "_last"}, 64'(bus.m_last), 64'(l));
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      chk("idle_valid", 64'(bus.m_valid), 64'(0));
      chk("idle_keep", 64'(bus.m_keep), 64'(0));
      chk("idle_ready", 64'(bus.s_ready), 64'(1));
      @(posedge clk);
      #2;
    end

    for (int i = 1; i <= 8; i++) begin
      put_beat(8'(i), 1'b0);
      if (i == 3 || i == 7)
        chk("lat_pre", 64'(bus.m_valid), 64'(0));
      if (i == 4)
        chk_word("w0", 32'h04030201, 4'hF, 1'b0);
      if (i == 8)
        chk_word("w1", 32'h08070605, 4'hF, 1'b0);
    end
    idle(2);

    for (int i = 0; i < 6; i++) begin
      put_beat(8'(8'hA0 + i), i == 5);
      if (i == 3)
        chk_word("pk_full", 32'hA3A2A1A0, 4'hF, 1'b0);
      if (i == 5)
        chk_word("pk_part", 32'h0000A5A4, 4'h3, 1'b1);
    end
    idle(2);

    put_beat(8'h5C, 1'b1);
    chk_word("single", 32'h0000005C, 4'h1, 1'b1);
    idle(2);

    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) put_beat(8'(8'h10 + i), 1'b0);
    bus.s_data = 8'h14;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 64'(bus.s_ready), 64'(0));
      chk_word("bp", 32'h13121110, 4'hF, 1'b0);
      @(posedge clk);
      #2;
    end
    bus.m_ready = 1'b1;
    for (int i = 4; i < 8; i++) put_beat(8'(8'h10 + i), 1'b0);
    idle(1);
    drain();

    rand_mr = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 1) == 1) idle(1);
      put_beat(8'($urandom), $urandom_range(0, 7) == 0);
    end
    put_beat(8'hFF, 1'b1);
    idle(1);
    rand_mr     = 1'b0;
    bus.m_ready = 1'b1;
    drain();

    put_beat(8'hE0, 1'b0);
    put_beat(8'hE1, 1'b0);
    bus.s_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.m_valid), 64'(0));
    chk("rst_data", 64'(bus.m_data), 64'(0));
    chk("rst_keep", 64'(bus.m_keep), 64'(0));
    chk("rst_last", 64'(bus.m_last), 64'(0));
    chk("rst_ready", 64'(bus.s_ready), 64'(1));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) put_beat(8'(8'h31 + i), 1'b0);
    chk_word("post_rst", 32'h34333231, 4'hF, 1'b0);
    idle(3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
